sa_feed_scheduler: RTL and testbench

Sequences reads from the per-column weight FIFO array (north) and the per-row data FIFO array (west) that feed the systolic array. On a start command it issues a diagonally skewed read wavefront: column c and row r each read i_len consecutive words, delayed by c and r cycles respectively. The wavefront stalls globally if any lane due to read is empty. It drives the north and west read-enable buses in place of external per-lane enables and reports busy, stall and done status.

---
 rtl/sa_ctrl_pkg.sv | 14 +
 rtl/skew_window.sv | 20 ++
 rtl/sa_feed_scheduler.sv | 106 ++++++++++
 tb/tb_sa_feed_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared state encoding and helpers for the systolic-array feed scheduler.
package sa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/skew_window.sv
// Active-lane mask of a diagonally skewed wavefront:
// lane i is live while i <= t < i + len.
module skew_window #(
  parameter int N   = 4,
  parameter int W_T = 18
) (
  input  logic [W_T-1:0] i_t,
  input  logic [W_T-1:0] i_len,
  output logic [N-1:0]   o_act
);

  always_comb begin
    o_act = '0;
    for (int i = 0; i < N; i++) begin
      o_act[i] = (i_t >= W_T'(i)) &&
                 (i_t < W_T'(i) + i_len);
    end
  end

endmodule

// File: rtl/sa_feed_scheduler.sv
// Skewed read-wavefront sequencer for the north/west FIFO arrays
// feeding the systolic array; stalls the whole front on any empty lane.
module sa_feed_scheduler
  import sa_ctrl_pkg::*;
#(
  parameter int ROW = 9,
  parameter int COL = 64,
  parameter int W_K = 10,
  parameter int W_T = W_K + 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [W_K-1:0] i_len,
  input  logic [COL-1:0] i_north_empty,
  input  logic [ROW-1:0] i_west_empty,
  output logic [COL-1:0] o_north_rden,
  output logic [ROW-1:0] o_west_rden,
  output logic           o_busy,
  output logic           o_stall,
  output logic           o_done
);

  localparam int SPAN = max_int(ROW, COL);

  state_t         state_q, state_d;
  logic [W_T-1:0] t_q, t_d;
  logic [W_K-1:0] len_q, len_d;
  logic [W_T-1:0] len_w, last_t;
  logic [COL-1:0] act_n;
  logic [ROW-1:0] act_w;
  logic           run, stall, adv;

  assign len_w  = W_T'(len_q);
  assign last_t = len_w + W_T'(SPAN - 2);

  skew_window #(.N(COL), .W_T(W_T)) u_north_win (
    .i_t   (t_q),
    .i_len (len_w),
    .o_act (act_n)
  );

  skew_window #(.N(ROW), .W_T(W_T)) u_west_win (
    .i_t   (t_q),
    .i_len (len_w),
    .o_act (act_w)
  );

  assign run   = (state_q == RUN);
  assign stall = run && ((|(act_n & i_north_empty)) ||
                         (|(act_w & i_west_empty)));
  assign adv   = run && !stall;

  assign o_north_rden = adv ? act_n : '0;
  assign o_west_rden  = adv ? act_w : '0;
  assign o_busy       = (state_q != IDLE);
  assign o_stall      = stall;
  assign o_done       = (state_q == DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            state_d = RUN;
            t_d     = '0;
            len_d   = i_len;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // abort wins over both advance and completion
        if (i_abort) begin
          state_d = IDLE;
        end else if (adv) begin
          if (t_q == last_t) begin
            state_d = DONE;
          end else begin
            t_d = t_q + W_T'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sa_feed_scheduler.sv
// Bench for sa_feed_scheduler: directed wavefront scenarios plus
// randomized traffic against an in-bench wavefront model.
module tb_sa_feed_scheduler;

  localparam int ROW  = 3;
  localparam int COL  = 4;
  localparam int W_K  = 10;
  localparam int W_T  = 18;
  localparam int SPAN = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [W_K-1:0] len = '0;
  logic [COL-1:0] n_empty = '0;
  logic [ROW-1:0] w_empty = '0;
  logic [COL-1:0] n_rden;
  logic [ROW-1:0] w_rden;
  logic           busy, stall, done;

  always #5 clk = ~clk;

  sa_feed_scheduler #(
    .ROW(ROW), .COL(COL), .W_K(W_K), .W_T(W_T)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .i_len         (len),
    .i_north_empty (n_empty),
    .i_west_empty  (w_empty),
    .o_north_rden  (n_rden),
    .o_west_rden   (w_rden),
    .o_busy        (busy),
    .o_stall       (stall),
    .o_done        (done)
  );

  int n_chk = 0;
  int n_fail = 0;

  // wavefront model: phase 0 idle, 1 running, 2 done
  int m_phase = 0;
  int m_t = 0;
  int m_L = 0;
  int rd_cnt[ROW+COL];

  int cyc = 0;
  int done_cyc = -1;
  int busy_cnt = 0;
  int f_n0 = -1;
  int f_n3 = -1;
  int f_w2 = -1;
  int s_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               name, cyc, act, exp);
    end
  endtask

  // called at posedge+1 with inputs already driven
  task automatic step();
    logic [COL-1:0] an, en;
    logic [ROW-1:0] aw, ew;
    bit st;
    int bad;
    an = '0; en = '0; aw = '0; ew = '0; st = 0;
    #3;
    if (m_phase == 1) begin
      for (int c = 0; c < COL; c++)
        if (c <= m_t && m_t < c + m_L) begin
          an[c] = 1'b1;
          if (n_empty[c]) st = 1;
        end
      for (int r = 0; r < ROW; r++)
        if (r <= m_t && m_t < r + m_L) begin
          aw[r] = 1'b1;
          if (w_empty[r]) st = 1;
        end
      if (!st) begin
        en = an;
        ew = aw;
      end
    end
    chk("north_rden", 64'(n_rden), 64'(en));
    chk("west_rden", 64'(w_rden), 64'(ew));
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("stall", 64'(stall), 64'(st));
    chk("done", 64'(done), 64'(m_phase == 2));
    if (done && done_cyc < 0) done_cyc = cyc;
    if (stall && s_cyc < 0) s_cyc = cyc;
    if (n_rden[0] && f_n0 < 0) f_n0 = cyc;
    if (n_rden[3] && f_n3 < 0) f_n3 = cyc;
    if (w_rden[2] && f_w2 < 0) f_w2 = cyc;
    if (busy) busy_cnt++;
    for (int c = 0; c < COL; c++) rd_cnt[c] += int'(n_rden[c]);
    for (int r = 0; r < ROW; r++) rd_cnt[COL+r] += int'(w_rden[r]);
    @(posedge clk);
    case (m_phase)
      0: if (start && rst_n) begin
        if (len != 0) begin
          m_phase = 1;
          m_t = 0;
          m_L = int'(len);
          for (int i = 0; i < ROW + COL; i++) rd_cnt[i] = 0;
        end else begin
          m_phase = 2;
        end
      end
      1: if (abort) m_phase = 0;
         else if (!st) begin
           if (m_t == m_L + SPAN - 2) begin
             m_phase = 2;
             bad = 0;
             for (int i = 0; i < ROW + COL; i++)
               if (rd_cnt[i] != m_L) bad++;
             chk("lane_reads_bad", 64'(bad), 64'd0);
           end else m_t++;
         end
      default: m_phase = 0;
    endcase
    cyc++;
    #1;
  endtask

  task automatic start_run(input int l);
    start = 1'b1;
    len = W_K'(l);
    cyc = 0;
    done_cyc = -1;
    busy_cnt = 0;
    f_n0 = -1; f_n3 = -1; f_w2 = -1; s_cyc = -1;
    step();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < ROW + COL; i++) rd_cnt[i] = 0;
    #2;
    chk("rst_north", 64'(n_rden), 64'd0);
    chk("rst_west", 64'(w_rden), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // basic wavefront, len 2
    start_run(2);
    repeat (7) step();
    chk("t1_done_cyc", 64'(done_cyc), 64'd6);
    chk("t1_busy_cnt", 64'(busy_cnt), 64'd6);
    chk("t1_first_n0", 64'(f_n0), 64'd1);
    chk("t1_first_n3", 64'(f_n3), 64'd4);
    chk("t1_first_w2", 64'(f_w2), 64'd3);

    // stall on active lane 1 in cycle 2
    start_run(2);
    step();
    n_empty = 4'b0010;
    step();
    n_empty = '0;
    repeat (6) step();
    chk("t2_stall_cyc", 64'(s_cyc), 64'd2);
    chk("t2_done_cyc", 64'(done_cyc), 64'd7);

    // empty inactive lane 3 in cycle 2: no stall
    start_run(2);
    step();
    n_empty = 4'b1000;
    step();
    n_empty = '0;
    repeat (6) step();
    chk("t2b_stall_cyc", 64'(s_cyc), 64'hffff_ffff_ffff_ffff);
    chk("t2b_done_cyc", 64'(done_cyc), 64'd6);

    // zero length
    start_run(0);
    repeat (3) step();
    chk("t3_done_cyc", 64'(done_cyc), 64'd1);
    chk("t3_busy_cnt", 64'(busy_cnt), 64'd1);
    chk("t3_first_n0", 64'(f_n0), 64'hffff_ffff_ffff_ffff);

    // ignored start in cycle 2, abort in cycle 3
    start_run(5);
    step();
    start = 1'b1;
    len = W_K'(3);
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("t4_busy_c4", 64'(busy), 64'd0);
    repeat (10) step();
    chk("t4_done_cyc", 64'(done_cyc), 64'hffff_ffff_ffff_ffff);
    chk("t4_busy_cnt", 64'(busy_cnt), 64'd3);

    // async reset mid-run
    start_run(5);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_north", 64'(n_rden), 64'd0);
    chk("t5_rst_west", 64'(w_rden), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    m_phase = 0;
    @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    step();
    start_run(1);
    repeat (6) step();
    chk("t5_done_cyc", 64'(done_cyc), 64'd5);
    chk("t5_busy_cnt", 64'(busy_cnt), 64'd5);

    // randomized traffic
    repeat (3000) begin
      start = (m_phase == 0) && ($urandom_range(0, 3) == 0);
      len = W_K'($urandom_range(0, 7));
      abort = ($urandom_range(0, 49) == 0);
      n_empty = COL'($urandom & $urandom & $urandom);
      w_empty = ROW'($urandom & $urandom & $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
